// File: rtl/mlp_hidden_mac.sv
// mlp_hidden_mac: hidden-layer MAC of the O/X MLP, all N neurons in parallel, one feature per cycle.
// Latency: M+1 cycles from the accept edge to out_valid; one vector in flight, period M+3 at best.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready is sampled high.
//
// Ports:
//   clk, rst_n       - rising-edge clock, asynchronous active-low reset
//   in_valid/ready   - accept handshake for x_bus, w_h_bus and b_h_bus (all latched together)
//   x_bus            - M signed W-bit features, feature m at [m*W +: W]
//   w_h_bus          - N*M signed W-bit weights, w[n][m] at [(n*M+m)*W +: W]
//   b_h_bus          - N signed W-bit biases, b[n] at [n*W +: W]
//   out_valid/ready  - result handshake
//   busy             - high while accumulating or finishing
//   h_raw_bus        - N signed (W+5)-bit raw scores, neuron n at [n*(W+5) +: W+5]
//
// Build option: define MLP_HIDDEN_SAT_EN to saturate each score to the (W+5)-bit
// signed range; otherwise scores wrap to their low W+5 bits.
module mlp_hidden_mac #(
  parameter int W     = 8,
  parameter int N     = 8,
  parameter int M     = 9,
  parameter int SHIFT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [M*W-1:0]       x_bus,
  input  logic [N*M*W-1:0]     w_h_bus,
  input  logic [N*W-1:0]       b_h_bus,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic [N*(W+5)-1:0]   h_raw_bus
);

  localparam int ACC_W = 2*W + 4;              // headroom for 16 full-scale products
  localparam int P_W   = 2*W;                  // one signed product
  localparam int HW    = W + 5;                // width of one output score
  localparam int KW    = (M > 1) ? $clog2(M) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(M - 1);

`ifdef MLP_HIDDEN_SAT_EN
  localparam int RW = ACC_W + 1;               // shifted sum plus bias, no overflow
  localparam logic signed [RW-1:0] R_MAX = $signed({{(RW-HW+1){1'b0}}, {(HW-1){1'b1}}});
  localparam logic signed [RW-1:0] R_MIN = $signed({{(RW-HW+1){1'b1}}, {(HW-1){1'b0}}});
  localparam logic [HW-1:0] H_MAX = {1'b0, {(HW-1){1'b1}}};
  localparam logic [HW-1:0] H_MIN = {1'b1, {(HW-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [KW-1:0]             k_q, k_d;
  logic signed [W-1:0]       x_q [M];
  logic signed [W-1:0]       x_d [M];
  logic signed [W-1:0]       w_q [N][M];
  logic signed [W-1:0]       w_d [N][M];
  logic signed [W-1:0]       b_q [N];
  logic signed [W-1:0]       b_d [N];
  logic signed [ACC_W-1:0]   acc_q [N];
  logic signed [ACC_W-1:0]   acc_d [N];
  logic [N*HW-1:0]           h_raw_q, h_raw_d;
  logic                      out_valid_q, out_valid_d;
  logic                      in_ready_q, in_ready_d;
  logic                      busy_q, busy_d;

  always_comb begin
    logic signed [P_W-1:0] prod;
`ifdef MLP_HIDDEN_SAT_EN
    logic signed [ACC_W-1:0] acc_sh;
    logic signed [RW-1:0]    r;
`endif
    state_d     = state_q;
    k_d         = k_q;
    x_d         = x_q;
    w_d         = w_q;
    b_d         = b_q;
    acc_d       = acc_q;
    h_raw_d     = h_raw_q;
    out_valid_d = out_valid_q;
    prod        = '0;
`ifdef MLP_HIDDEN_SAT_EN
    acc_sh      = '0;
    r           = '0;
`endif

    case (state_q)
      IDLE: begin
        // in_ready_q gates acceptance so nothing is taken in the cycle
        // right after reset release, when in_ready is still low.
        if (in_valid && in_ready_q) begin
          for (int m = 0; m < M; m++) begin
            x_d[m] = x_bus[m*W +: W];
          end
          for (int n = 0; n < N; n++) begin
            for (int m = 0; m < M; m++) begin
              w_d[n][m] = w_h_bus[(n*M+m)*W +: W];
            end
            b_d[n]   = b_h_bus[n*W +: W];
            acc_d[n] = '0;
          end
          k_d     = '0;
          state_d = ACC;
        end
      end

      ACC: begin
        for (int n = 0; n < N; n++) begin
          prod     = x_q[k_q] * w_q[n][k_q];
          acc_d[n] = acc_q[n] + {{(ACC_W-P_W){prod[P_W-1]}}, prod};
        end
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = FIN;
        end else begin
          k_d = k_q + KW'(1);
        end
      end

      FIN: begin
        for (int n = 0; n < N; n++) begin
`ifdef MLP_HIDDEN_SAT_EN
          acc_sh = acc_q[n] >>> SHIFT;
          r      = {acc_sh[ACC_W-1], acc_sh} + {{(RW-W){b_q[n][W-1]}}, b_q[n]};
          if (r > R_MAX) begin
            h_raw_d[n*HW +: HW] = H_MAX;
          end else if (r < R_MIN) begin
            h_raw_d[n*HW +: HW] = H_MIN;
          end else begin
            h_raw_d[n*HW +: HW] = r[HW-1:0];
          end
`else
          // Wrapping result: the low HW bits of (acc >>> SHIFT) are exactly
          // acc[SHIFT +: HW], so the full-width shift is never built.
          h_raw_d[n*HW +: HW] = acc_q[n][SHIFT +: HW] + {{(HW-W){b_q[n][W-1]}}, b_q[n]};
`endif
        end
        out_valid_d = 1'b1;
        state_d     = DONE;
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Flag outputs follow the next state so they are registered yet aligned
    // with the state they describe.
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d == ACC) || (state_d == FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      h_raw_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      for (int m = 0; m < M; m++) begin
        x_q[m] <= '0;
      end
      for (int n = 0; n < N; n++) begin
        for (int m = 0; m < M; m++) begin
          w_q[n][m] <= '0;
        end
        b_q[n]   <= '0;
        acc_q[n] <= '0;
      end
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      x_q         <= x_d;
      w_q         <= w_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      h_raw_q     <= h_raw_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign h_raw_bus = h_raw_q;

endmodule

// File: tb/tb_mlp_hidden_mac.sv
module tb_mlp_hidden_mac;

  localparam int W  = 8;
  localparam int N  = 8;
  localparam int M  = 9;
  localparam int HW = W + 5;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [M*W-1:0]     x_bus = '0;
  logic [N*M*W-1:0]   w_h_bus = '0;
  logic [N*W-1:0]     b_h_bus = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic               busy;
  logic [N*HW-1:0]    h_raw_bus;

  int xv [M];
  int wv [N][M];
  int bv [N];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mlp_hidden_mac #(.W(W), .N(N), .M(M), .SHIFT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_bus     (x_bus),
    .w_h_bus   (w_h_bus),
    .b_h_bus   (b_h_bus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .h_raw_bus (h_raw_bus)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer dot product, floor division by 16, bias add,
  // then clamp or two's-complement wrap into a 13-bit score.
  function automatic int model(input int n);
    int sum, q, r;
    sum = 0;
    for (int m = 0; m < M; m++) sum += xv[m] * wv[n][m];
    q = sum / 16;
    if ((sum % 16 != 0) && (sum < 0)) q -= 1;
    r = q + bv[n];
`ifdef MLP_HIDDEN_SAT_EN
    if (r > 4095) r = 4095;
    if (r < -4096) r = -4096;
`else
    r = ((r % 8192) + 8192) % 8192;
    if (r >= 4096) r -= 8192;
`endif
    return r;
  endfunction

  function automatic logic signed [HW-1:0] field(input int n);
    return h_raw_bus[n*HW +: HW];
  endfunction

  task automatic set_uniform(input int xval, input int wval, input int bval);
    for (int m = 0; m < M; m++) xv[m] = xval;
    for (int n = 0; n < N; n++) begin
      for (int m = 0; m < M; m++) wv[n][m] = wval;
      bv[n] = bval;
    end
  endtask

  task automatic set_random();
    for (int m = 0; m < M; m++) xv[m] = int'($urandom_range(0, 255)) - 128;
    for (int n = 0; n < N; n++) begin
      for (int m = 0; m < M; m++) wv[n][m] = int'($urandom_range(0, 255)) - 128;
      bv[n] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  task automatic load();
    for (int m = 0; m < M; m++) x_bus[m*W +: W] = W'(xv[m]);
    for (int n = 0; n < N; n++) begin
      for (int m = 0; m < M; m++) w_h_bus[(n*M+m)*W +: W] = W'(wv[n][m]);
      b_h_bus[n*W +: W] = W'(bv[n]);
    end
  endtask

  // Waits (bounded) for in_ready, presents the vector for one edge, returns
  // at the negedge following the accept edge.
  task automatic start(input string tag);
    int cnt;
    cnt = 0;
    while (in_ready !== 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, " in_ready before accept"}, in_ready, 1);
    load();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, " busy after accept"}, busy, 1);
    chk({tag, " in_ready after accept"}, in_ready, 0);
  endtask

  task automatic wait_out(input string tag);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, M + 1);
  endtask

  task automatic check_scores(input string tag);
    for (int n = 0; n < N; n++) chk($sformatf("%s n%0d", tag, n), field(n), model(n));
  endtask

  task automatic run(input string tag);
    start(tag);
    wait_out(tag);
    check_scores(tag);
    @(negedge clk);
    chk({tag, " out_valid cleared"}, out_valid, 0);
    chk({tag, " in_ready back"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N*HW-1:0] hold;

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    chk("reset in_ready", in_ready, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset h_raw zero", (h_raw_bus === '0), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready after release", in_ready, 1);

    // Directed vectors.
    set_uniform(1, 16, 0);
    run("ones_x16");
    set_uniform(127, -128, 0);
    run("neg_full_scale");
    set_uniform(0, 5, 0);
    for (int n = 0; n < N; n++) bv[n] = n - 4;
    run("bias_only");
    set_uniform(0, 0, 0);
    xv[0] = 1;
    for (int n = 0; n < N; n++) wv[n][0] = -1;
    run("floor_minus_one");
    set_uniform(127, 127, 127);
    run("pos_full_scale");

    // Randomized vectors back to back.
    for (int t = 0; t < 6; t++) begin
      set_random();
      run($sformatf("rand%0d", t));
    end

    // Backpressure: result must hold while out_ready is low.
    set_uniform(1, 16, 0);
    out_ready = 1'b0;
    start("hold");
    wait_out("hold");
    check_scores("hold");
    hold = h_raw_bus;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      x_bus = {$urandom, $urandom, $urandom};
      @(negedge clk);
      chk($sformatf("hold out_valid c%0d", i), out_valid, 1);
      chk($sformatf("hold in_ready c%0d", i), in_ready, 0);
      chk($sformatf("hold h_raw stable c%0d", i), (h_raw_bus === hold), 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("hold release out_valid", out_valid, 0);
    chk("hold release in_ready", in_ready, 1);
    chk("hold release not busy", busy, 0);
    chk("hold release h_raw kept", (h_raw_bus === hold), 1);

    // Asynchronous reset in the 4th ACC cycle.
    set_uniform(2, 16, 1);
    start("midreset");
    repeat (3) @(negedge clk);
    chk("midreset busy before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset out_valid", out_valid, 0);
    chk("midreset busy", busy, 0);
    chk("midreset in_ready", in_ready, 0);
    chk("midreset h_raw zero", (h_raw_bus === '0), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset in_ready after release", in_ready, 1);
    set_uniform(1, 16, 0);
    run("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mlp_hidden_mac.md
# mlp_hidden_mac

Hidden-layer MAC stage of the O/X detecting MLP. It accepts one input-feature vector per transaction and computes the raw, pre-activation hidden scores for all N neurons in parallel, one input feature per cycle. It presents the scores on the flattened `h_raw_bus` that feeds the output-score stage. A ready/valid handshake on both sides decouples it from the feature source and from the output-stage controller.

## Interface
- `W`, 8: signed width of features, weights and biases.
- `N`, 8: hidden neuron count.
- `M`, 9: input features per vector (3x3 image); legal range 1..16.
- `SHIFT`, 4: arithmetic right shift applied to the accumulated dot product.
- `clk`  input  1  sole clock; rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  feature vector and weights valid.
- `in_ready`  output  1  block can accept a vector.
- `x_bus`  input  M*W  signed features; feature m at `[m*W +: W]`.
- `w_h_bus`  input  N*M*W  signed weights; w[n][m] at `[(n*M+m)*W +: W]`.
- `b_h_bus`  input  N*W  signed biases; b[n] at `[n*W +: W]`.
- `out_valid`  output  1  `h_raw_bus` holds a new result.
- `out_ready`  input  1  consumer takes the result.
- `busy`  output  1  high in ACC or FIN.
- `h_raw_bus`  output  N*(W+5)  signed raw scores; neuron n at `[n*(W+5) +: W+5]`.

## Operation
- FSM states: IDLE, ACC, FIN, DONE.
- IDLE: `in_ready`=1.
  - On `in_valid`, latch `x_bus`, `w_h_bus` and `b_h_bus` into internal registers.
  - Clear all N accumulators, set index k=0, go to ACC.
- ACC: on each edge, acc[n] += x[k]*w[n][k] for all n, then k++.
  - After the edge that adds k=M-1, go to FIN.
  - Inputs are ignored while in ACC; the latched copies are used.
- FIN: for each n, r = (acc[n] >>> SHIFT) + sign-extended b[n].
  - Reduce r to W+5 bits per the SAT macro and register it into `h_raw_bus`.
  - Set `out_valid`=1 and go to DONE.
- DONE: hold `h_raw_bus` and `out_valid`.
  - When `out_ready`=1 at an edge, clear `out_valid` and go to IDLE.
  - `in_ready` stays 0 in DONE. No same-cycle re-accept.
- Arithmetic:
  - Each product is a 2W-bit signed value.
  - Accumulators are ACC_W = 2W+4 bits, so no overflow is possible for M≤16.
  - `>>>` is an arithmetic shift and floors toward negative infinity; there is no rounding.
- `h_raw_bus` keeps its last value until the next FIN. The downstream stage samples it freely.
- Reset, including reset asserted mid-ACC or mid-DONE:
  - `in_ready`=0 while `rst_n` is low, then 1 once in IDLE.
  - `out_valid`=0, `busy`=0, `h_raw_bus`=0.
  - Accumulators and k are 0, state is IDLE.
  - A partial transaction is discarded.

## Timing
- Accept edge E0: the edge where `in_valid & in_ready` is sampled.
- E1..EM: accumulate features 0..M-1.
- E(M+1): FIN registers the result. `out_valid` is high after E(M+1), so latency is M+1 cycles (10 at default).
- `busy` is high from after E0 until after E(M+1).
- Minimum transaction period: M+3 cycles, with `out_ready` tied high and `in_valid` asserted again immediately.
- `out_ready` is a don't-care outside DONE. `in_valid` is a don't-care outside IDLE.
- All outputs are registered. There are no combinational paths from input to output.

## Configuration
- `MLP_HIDDEN_SAT_EN` defined: r is saturated to [-2^(W+4), 2^(W+4)-1], i.e. [-4096, 4095] at W=8.
- Undefined: r is truncated to its low W+5 bits (two's-complement wrap). This costs less area.

## Test plan
All scenarios use default parameters.

- All x=1, all w=16, all b=0 -> after 10 cycles `out_valid`=1 and every neuron = 9 (144>>>4).
- All x=127, all w=-128, b=0:
  - With `MLP_HIDDEN_SAT_EN`, every neuron = -4096.
  - Without it, every neuron = -952 (wrap of -9144).
- x=0, b[n]=n-4 -> neuron n = n-4, i.e. -4..3, correctly sign-extended in 13-bit fields.
- x[0]=1, w[n][0]=-1, all other x=0, b=0 -> every neuron = -1 (floor of -1>>>4).
- Hold `out_ready`=0 for 5 cycles after `out_valid`, pulsing `in_valid` throughout:
  - `h_raw_bus` and `out_valid` are stable and `in_ready`=0.
  - Raise `out_ready`: `out_valid` drops next edge and `in_ready`=1.
  - The next vector is accepted only after that.
- Assert `rst_n`=0 at the 4th ACC cycle:
  - `out_valid`, `busy` and `h_raw_bus` go to 0 immediately (async), with no edge needed.
  - After release, `in_ready`=1 and a fresh all-ones/16 vector yields 9.
